// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage. Issues one read at a time to
// instruction memory, presents fetched words in program order on a
// registered output, parks one word while downstream stalls, and drains
// wrong-path reads after a branch redirect.
//
// Handshakes:
//   memory side - imem_req/imem_addr come from registers and stay stable
//                 until a cycle with imem_ready=1 completes the read; a
//                 ready seen while imem_req=0 is ignored.
//   output side - the word on if_pc/if_inst with if_valid=1 is taken by
//                 downstream in every cycle with stall=0; with stall=1 it
//                 is held unchanged.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // read outstanding at pc
        HOLD  = 2'd1,  // one word parked, memory idle
        KILL  = 2'd2   // wrong-path read at kill_addr still outstanding
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] kill_addr, kill_addr_n;
    logic [31:0] hold_pc, hold_pc_n;
    logic [31:0] hold_inst, hold_inst_n;
    logic [31:0] out_pc_n, out_inst_n;
    logic        out_valid_n;

    // Memory request decoded from registers; masked while reset is applied
    // so no read is issued in any reset cycle.
    always_comb begin
        imem_req  = (state != HOLD) && !rst;
        imem_addr = (state == KILL) ? kill_addr : pc;
    end

    // Next-state, next-pc and next-output selection.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        kill_addr_n = kill_addr;
        hold_pc_n   = hold_pc;
        hold_inst_n = hold_inst;
        out_pc_n    = if_pc;
        out_inst_n  = if_inst;
        out_valid_n = if_valid;

        if (branch_flag) begin
            // Redirect wins over stall and ready: flush output and parked word.
            pc_n        = branch_target & 32'hFFFF_FFFC;
            out_pc_n    = 32'h0;
            out_inst_n  = 32'h0;
            out_valid_n = 1'b0;
            hold_pc_n   = 32'h0;
            hold_inst_n = 32'h0;
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state_n = FETCH;
                    end else begin
                        // Keep driving the old address until memory answers.
                        state_n     = KILL;
                        kill_addr_n = pc;
                    end
                end
                // A newer target replaces the stored one; if the old read
                // completes in this same cycle there is nothing left to drain.
                KILL:    state_n = imem_ready ? FETCH : KILL;
                HOLD:    state_n = FETCH;
                default: state_n = FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc_n = pc + 32'd4;
                        if (!if_valid || !stall) begin
                            out_pc_n    = pc;
                            out_inst_n  = imem_rdata;
                            out_valid_n = 1'b1;
                        end else begin
                            // Output slot busy: park the word and idle memory.
                            hold_pc_n   = pc;
                            hold_inst_n = imem_rdata;
                            state_n     = HOLD;
                        end
                    end else if (!stall) begin
                        out_valid_n = 1'b0;
                        out_inst_n  = 32'h0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_pc_n    = hold_pc;
                        out_inst_n  = hold_inst;
                        out_valid_n = 1'b1;
                        state_n     = FETCH;
                    end
                end
                KILL: begin
                    // Wrong-path word is dropped; resume at the stored target.
                    if (imem_ready) begin
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // State, pc, parked word and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            kill_addr <= 32'h0;
            hold_pc   <= 32'h0;
            hold_inst <= 32'h0;
            if_pc     <= 32'h0;
            if_inst   <= 32'h0;
            if_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            kill_addr <= kill_addr_n;
            hold_pc   <= hold_pc_n;
            hold_inst <= hold_inst_n;
            if_pc     <= out_pc_n;
            if_inst   <= out_inst_n;
            if_valid  <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios with a scoreboard of expected
// {pc, inst} pairs and a negedge monitor that pops on every consumed output.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;

  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;

  logic        imem_req2, imem_ready2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic [31:0] if_pc2, if_inst2;
  logic        if_valid2;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int wait_cnt = 0;

  logic [63:0] exp_q[$];

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Memory image: every address returns a distinct word.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  pc_fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
    .if_pc(if_pc2), .if_inst(if_inst2), .if_valid(if_valid2)
  );

  // Memory model: answers after mem_wait cycles of an outstanding request.
  assign imem_ready  = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata  = word(imem_addr);
  assign imem_ready2 = imem_req2;
  assign imem_rdata2 = word(imem_addr2);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Driver / check tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back({a, word(a)});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    check("rst_req_low", {31'h0, imem_req}, 32'h0);
    step();
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    stall = 1'b0;
    branch_flag = 1'b0;
    branch_target = 32'h0;
    rst = 1'b0;
    #1;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
  endtask

  // Scoreboard monitor: an output is consumed when valid with stall=0.
  always @(negedge clk) begin
    logic [63:0] got;
    if (!rst && if_valid === 1'b1 && stall === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual pc=%h inst=%h required none", if_pc, if_inst);
      end else begin
        got = exp_q.pop_front();
        if ({if_pc, if_inst} !== got) begin
          errors++;
          $display("FAIL out_order actual pc=%h inst=%h required pc=%h inst=%h",
                   if_pc, if_inst, got[63:32], got[31:0]);
        end
      end
    end
    if (!rst && if_valid === 1'b0) begin
      checks++;
      if (if_inst !== 32'h0) begin
        errors++;
        $display("FAIL nop_when_invalid actual=%h required=00000000", if_inst);
      end
    end
  end

  // Directed scenarios
  initial begin
    // Zero-wait streaming, stall with parking, wrap on the second instance.
    mem_wait = 0;
    apply_reset();
    check("wrap_first_addr", imem_addr2, 32'hFFFF_FFF8);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    step();
    check("wrap_pc0", if_pc2, 32'hFFFF_FFF8);
    step();
    check("wrap_pc1", if_pc2, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", if_pc2, 32'h0000_0000);
    check("wrap_valid", {31'h0, if_valid2}, 32'h1);
    check("zw_pc8", if_pc, 32'h8);
    stall = 1'b1;
    step();
    check("hold_pc", if_pc, 32'h8);
    check("hold_req", {31'h0, imem_req}, 32'h0);
    step();
    step();
    check("hold_pc_3", if_pc, 32'h8);
    check("hold_inst_3", if_inst, word(32'h8));
    check("hold_req_3", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    step();
    check("unpark_pc", if_pc, 32'hC);
    check("unpark_valid", {31'h0, if_valid}, 32'h1);
    check("unpark_req", {31'h0, imem_req}, 32'h1);
    check("unpark_addr", imem_addr, 32'h10);
    step();
    stall = 1'b1;
    step();

    // Two-wait memory, branch while 0x4 outstanding.
    mem_wait = 2;
    apply_reset();
    push(32'h0);
    step(); step(); step();
    check("w2_pc0", if_pc, 32'h0);
    branch_flag = 1'b1;
    branch_target = 32'h103;
    step();
    branch_flag = 1'b0;
    check("kill_valid", {31'h0, if_valid}, 32'h0);
    check("kill_req", {31'h0, imem_req}, 32'h1);
    check("kill_addr_a", imem_addr, 32'h4);
    step();
    check("kill_addr_b", imem_addr, 32'h4);
    step();
    check("redirect_addr", imem_addr, 32'h100);
    check("redirect_valid", {31'h0, if_valid}, 32'h0);
    push(32'h100);
    step(); step(); step();
    check("redirect_pc", if_pc, 32'h100);
    step();
    stall = 1'b1;

    // Branch and stall in the same cycle.
    mem_wait = 0;
    apply_reset();
    push(32'h0);
    step(); step();
    branch_flag = 1'b1;
    branch_target = 32'h200;
    stall = 1'b1;
    step();
    branch_flag = 1'b0;
    stall = 1'b0;
    check("bs_valid", {31'h0, if_valid}, 32'h0);
    check("bs_pc", if_pc, 32'h0);
    check("bs_addr", imem_addr, 32'h200);
    push(32'h200); push(32'h204);
    step();
    check("bs_first", if_pc, 32'h200);
    step(); step();
    stall = 1'b1;
    step();

    // Branch while in HOLD, unaligned target.
    apply_reset();
    push(32'h0);
    step(); step();
    stall = 1'b1;
    step();
    check("hb_hold_req", {31'h0, imem_req}, 32'h0);
    branch_flag = 1'b1;
    branch_target = 32'h502;
    step();
    branch_flag = 1'b0;
    stall = 1'b0;
    check("hb_valid", {31'h0, if_valid}, 32'h0);
    check("hb_req", {31'h0, imem_req}, 32'h1);
    check("hb_addr", imem_addr, 32'h500);
    push(32'h500); push(32'h504);
    step(); step(); step();
    stall = 1'b1;
    step();

    // Three-wait memory: double branch in KILL, then reset in KILL.
    mem_wait = 3;
    apply_reset();
    branch_flag = 1'b1;
    branch_target = 32'h40;
    step();
    check("k2_addr_a", imem_addr, 32'h0);
    check("k2_req", {31'h0, imem_req}, 32'h1);
    branch_target = 32'h80;
    step();
    branch_flag = 1'b0;
    check("k2_addr_b", imem_addr, 32'h0);
    check("k2_valid", {31'h0, if_valid}, 32'h0);
    step();
    step();
    check("k2_target", imem_addr, 32'h80);
    check("k2_drop", {31'h0, if_valid}, 32'h0);
    push(32'h80);
    for (int i = 0; i < 5; i++) step();
    branch_flag = 1'b1;
    branch_target = 32'h300;
    step();
    branch_flag = 1'b0;
    rst = 1'b1;
    #1;
    check("rk_req_a", {31'h0, imem_req}, 32'h0);
    step();
    check("rk_valid", {31'h0, if_valid}, 32'h0);
    check("rk_pc", if_pc, 32'h0);
    check("rk_inst", if_inst, 32'h0);
    check("rk_req_b", {31'h0, imem_req}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rk_req_c", {31'h0, imem_req}, 32'h1);
    check("rk_addr", imem_addr, 32'h0);
    push(32'h0);
    for (int i = 0; i < 5; i++) step();
    stall = 1'b1;
    step();

    check("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
